// File: rtl/game_pkg.sv
// Shared types and helpers for the flappy bird game sequencer:
// FSM state encodings, frame tick line, BCD width and BCD increment.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam int TICK_LINE = 480;
  localparam int BCD_W     = 8;

  localparam logic [BCD_W-1:0] BCD_MAX = 8'h99;

  // Two-digit BCD increment that holds at 99.
  function automatic logic [BCD_W-1:0] bcd_inc(
    input logic [BCD_W-1:0] v
  );
    logic [BCD_W-1:0] r;
    if (v == BCD_MAX)
      r = v;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle between the game sequencer and the bird/wall movers.
// master: sequencer (drives tick/run/reset/flap, reads collide/wall_passed).
interface game_sequencer_if;

  logic frame_tick;
  logic game_run;
  logic movers_rst;
  logic flap_pulse;
  logic collide;
  logic wall_passed;

  modport master (
    output frame_tick,
    output game_run,
    output movers_rst,
    output flap_pulse,
    input  collide,
    input  wall_passed
  );

  modport slave (
    input  frame_tick,
    input  game_run,
    input  movers_rst,
    input  flap_pulse,
    output collide,
    output wall_passed
  );

endinterface

// File: rtl/btn_debounce.sv
// Button debouncer: 2-flop sync, stability counter, press strobe.
// Ports: i_clk, i_rst_n (sync, active low), i_btn raw, o_press strobe.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  logic             r_s0;
  logic             r_s1;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s0      <= 1'b0;
      r_s1      <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s0      <= i_btn;
      r_s1      <= r_s0;
      r_level_d <= r_level;
      // Any return to the accepted level restarts the count.
      if (r_s1 != r_level) begin
        if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/game_sequencer.sv
// Flappy bird game controller: frame tick, button debounce, phase FSM,
// BCD score/best. Ports: CLK, rst_n, v_counter, btn_flap, btn_start,
// mv (mover bundle), score, best, state, status.
module game_sequencer
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DEATH_FRAMES    = 60,
  parameter int CNT_W           = 20
) (
  input  logic                CLK,
  input  logic                rst_n,
  input  logic [9:0]          v_counter,
  input  logic                btn_flap,
  input  logic                btn_start,
  game_sequencer_if.master    mv,
  output logic [BCD_W-1:0]    score,
  output logic [BCD_W-1:0]    best,
  output logic [1:0]          state,
  output logic [15:0]         status
);

  localparam int DW = $clog2(DEATH_FRAMES + 1);

  logic [9:0]       r_vc0;
  logic [9:0]       r_vc1;
  logic [9:0]       r_vc_prev;
  logic             w_tick;
  logic             w_flap_press;
  logic             w_start_press;
  logic             w_flap;
  state_t           r_state;
  logic [BCD_W-1:0] r_score;
  logic [BCD_W-1:0] r_best;
  logic             r_game_run;
  logic             r_movers_rst;
  logic             r_boot;
  logic [DW-1:0]    r_death;

  // v_counter comes from the pixel clock domain.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_vc0     <= '0;
      r_vc1     <= '0;
      r_vc_prev <= '0;
    end else begin
      r_vc0     <= v_counter;
      r_vc1     <= r_vc0;
      r_vc_prev <= r_vc1;
    end
  end

  assign w_tick = (r_vc1 == 10'(TICK_LINE)) &&
                  (r_vc_prev != 10'(TICK_LINE));

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_flap (
    .i_clk   (CLK),
    .i_rst_n (rst_n),
    .i_btn   (btn_flap),
    .o_press (w_flap_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_start (
    .i_clk   (CLK),
    .i_rst_n (rst_n),
    .i_btn   (btn_start),
    .o_press (w_start_press)
  );

  // Flap goes out in the press cycle; a collision suppresses it.
  assign w_flap = (r_state == ST_PLAY) & w_flap_press & ~mv.collide;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_score      <= '0;
      r_best       <= '0;
      r_game_run   <= 1'b0;
      r_movers_rst <= 1'b0;
      r_boot       <= 1'b1;
      r_death      <= '0;
    end else begin
      // r_boot gives the single mover reset after reset release.
      r_boot       <= 1'b0;
      r_movers_rst <= r_boot;
      unique case (r_state)
        ST_IDLE: begin
          if (w_start_press | w_flap_press) begin
            r_movers_rst <= 1'b1;
            r_score      <= '0;
            r_game_run   <= 1'b1;
            r_state      <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (mv.collide) begin
            r_death    <= '0;
            r_game_run <= 1'b0;
            r_state    <= ST_DYING;
          end else if (mv.wall_passed) begin
            r_score <= bcd_inc(r_score);
          end
        end
        ST_DYING: begin
          if (w_tick) begin
            if (r_death == DW'(DEATH_FRAMES - 1)) begin
              r_state <= ST_OVER;
              // Packed BCD orders like plain unsigned.
              if (r_score > r_best)
                r_best <= r_score;
            end else begin
              r_death <= r_death + 1'b1;
            end
          end
        end
        ST_OVER: begin
          if (w_start_press) begin
            r_movers_rst <= 1'b1;
            r_score      <= '0;
            r_game_run   <= 1'b1;
            r_state      <= ST_PLAY;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mv.frame_tick = w_tick;
  assign mv.game_run   = r_game_run;
  assign mv.movers_rst = r_movers_rst;
  assign mv.flap_pulse = w_flap;

  assign score  = r_score;
  assign best   = r_best;
  assign state  = r_state;
  assign status = (r_state == ST_OVER) ?
                  {r_score, r_best} :
                  {r_score, 6'b0, r_state};

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game controller for the flappy bird design. Sequences the ball mover and both wall movers through attract, play, death and game-over phases.
- Generates the per-frame motion tick from the VGA counters and debounces the flap/start buttons.
- Keeps the BCD score and best score that feed the seven-segment display and the LED status bus.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable CLK cycles before a button level is accepted (10 ms at 100 MHz).
- TICK_LINE, 480, v_counter value whose first occurrence emits frame_tick (start of vertical blank).
- DEATH_FRAMES, 60, number of frame ticks spent in DYING before GAME_OVER.
- CNT_W, 20, width of the debounce counter.

Ports:
- CLK  in  1  system clock (100 MHz).
- rst_n  in  1  synchronous active-low reset.
- v_counter  in  10  VGA vertical counter (pixel-clock domain, sampled on CLK).
- btn_flap  in  1  raw flap button.
- btn_start  in  1  raw start/restart button.
- collide  in  1  level; bird overlaps a wall or a screen edge.
- wall_passed  in  1  single-CLK pulse when a wall pair's right edge passes bird X.
- frame_tick  out  1  single-CLK pulse, once per frame.
- game_run  out  1  movers advance on frame_tick only while high.
- movers_rst  out  1  high for exactly one CLK; resets bird and wall positions.
- flap_pulse  out  1  single-CLK pulse per accepted flap press, during PLAY only.
- score  out  8  two-digit BCD current score.
- best  out  8  two-digit BCD best score.
- state  out  2  encoded FSM state.
- status  out  16  {score, best} when in GAME_OVER; {score, 6'b0, state} otherwise.

Behaviour:
- Reset (rst_n low at a CLK edge) clears everything:
  - state=IDLE, score=0, best=0.
  - All pulses low, game_run=0.
  - movers_rst=1 for the cycle after reset release.
  - Debounce counters and filtered levels = 0.
- Frame tick:
  - v_counter passes through a 2-flop register.
  - frame_tick fires on the first CLK where the registered value equals TICK_LINE and the previous registered value did not.
  - Result: exactly one pulse per frame, latency 2 CLK.
- Debounce, per button:
  - Raw input is synchronised by 2 flops.
  - The counter increments while the synced value differs from the filtered level and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES-1 the filtered level flips.
  - A rising edge of the filtered level gives a one-cycle press strobe.
- FSM states: IDLE=0, PLAY=1, DYING=2, OVER=3.
  - IDLE: game_run=0. On a start press or flap press: movers_rst=1, score=0, go to PLAY.
  - PLAY: game_run=1. A flap press gives flap_pulse the same cycle. A wall_passed pulse increments score in BCD, saturating at 0x99. When collide is sampled high: death counter=0, go to DYING.
  - DYING: game_run=0. Count frame_ticks; at DEATH_FRAMES, go to OVER. On that same transition, if score>best then best=score (BCD compare = unsigned compare).
  - OVER: game_run=0. A start press gives movers_rst=1, score=0, go to PLAY. A flap press is ignored.
- Simultaneous events in PLAY:
  - collide beats wall_passed: the score does not increment in the collision cycle.
  - collide beats a flap press: no flap_pulse.
- BCD increment:
  - Ones digit 9 wraps to 0 with a carry into tens.
  - At 0x99 the score holds.
- Reset mid-game: returns to IDLE immediately, same values as power-up. best is cleared.

Decomposition:
- Shared package game_pkg holds:
  - state encodings (ST_IDLE, ST_PLAY, ST_DYING, ST_OVER),
  - TICK_LINE,
  - BCD width constant and the BCD increment function.
- One natural sub-module: btn_debounce (sync + counter + edge strobe), instantiated twice.

Test Plan:
- Reset then sweep v_counter 0..524 twice -> exactly 2 frame_tick pulses, each 2 CLK after v_counter=480; state=0, score=0x00.
- DEBOUNCE_CYCLES=8; btn_start bounces 0/1 every 3 cycles for 30 cycles then holds 1 -> a single press strobe; movers_rst one cycle; state=1; game_run=1.
- In PLAY, 12 wall_passed pulses -> score=0x12. Preload score to 0x98 and apply 3 pulses -> score=0x99 (saturated).
- In PLAY, assert collide and wall_passed in the same cycle with score=0x05 -> score stays 0x05, state=2. After DEATH_FRAMES ticks -> state=3, best=0x05, status=0x0505.
- In OVER, a flap press -> no change. Then a start press -> state=1, score=0, best retains 0x05. Then die at score 0x03 -> best stays 0x05.
- Deassert rst_n for one cycle while in PLAY with score 0x07 -> next cycle state=0, score=0, best=0, game_run=0, flap_pulse never asserted.
